// File: rtl/ram_access_sequencer.sv
// ram_access_sequencer: turns one-cycle request/response transactions into RAM control strobe sequences.
// Define RAM_SEQ_COPY_EN to compile in the block-copy operation (SETT/XWAIT/XFER states).
module ram_access_sequencer #(
  parameter int MAX_LEN = 256,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic             req_word,
  input  logic [14:0]      req_addr,
  input  logic [14:0]      req_dst,
  input  logic [LEN_W-1:0] req_len,
  input  logic [15:0]      req_wdata,
  output logic             rsp_valid,
  output logic [15:0]      rsp_rdata,
  output logic             rsp_err,
  input  logic [15:0]      ram_db_out,
  output logic [15:0]      data_bus,
  output logic             set_address,
  output logic             set_transfer_addr,
  output logic             read,
  output logic             write,
  output logic             data_transfer,
  output logic             half_mode
);

  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_COPY  = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] SETA  = 4'd1;
  localparam logic [3:0] RWAIT = 4'd2;
  localparam logic [3:0] RDAT  = 4'd3;
  localparam logic [3:0] WDAT  = 4'd4;
  localparam logic [3:0] DONE  = 4'd8;
`ifdef RAM_SEQ_COPY_EN
  localparam logic [3:0] SETT  = 4'd5;
  localparam logic [3:0] XWAIT = 4'd6;
  localparam logic [3:0] XFER  = 4'd7;
`endif

  logic [3:0]  state_q, state_d;
  logic [1:0]  op_q;
  logic        word_q;
  logic [14:0] addr_q;
  logic [15:0] wdata_q;
  logic        err_q;
  logic [15:0] rdata_q;
  logic        accept;
  logic        acceptErr;
  logic        acceptEmpty;

`ifdef RAM_SEQ_COPY_EN
  logic [14:0]      dst_q;
  logic [LEN_W-1:0] cnt_q;

  // Any byte of the range at or above 0x7F00 lands in the memory-mapped region.
  function automatic logic touchesMmio(input logic [14:0] base, input logic [LEN_W-1:0] len);
    logic [15:0] last;
    last = {1'b0, base} + 16'(len) - 16'd1;
    return last >= 16'h7F00;
  endfunction
`else
  logic unusedCopyPorts;
  assign unusedCopyPorts = ^{req_dst, req_len};
`endif

  assign accept    = req_valid && (state_q == IDLE);
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rdata_q;

  always_comb begin
    acceptErr   = (req_op == OP_RSVD);
    acceptEmpty = 1'b0;
`ifdef RAM_SEQ_COPY_EN
    if (req_op == OP_COPY) begin
      acceptEmpty = (req_len == '0);
      acceptErr   = !acceptEmpty &&
                    (touchesMmio(req_addr, req_len) || touchesMmio(req_dst, req_len));
    end
`else
    if (req_op == OP_COPY) acceptErr = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (acceptErr || acceptEmpty) state_d = DONE;
`ifdef RAM_SEQ_COPY_EN
          else if (req_op == OP_COPY)   state_d = SETT;
`endif
          else                          state_d = SETA;
        end
      end
      SETA: begin
        state_d = (op_q == OP_WRITE) ? WDAT : RWAIT;
`ifdef RAM_SEQ_COPY_EN
        if (op_q == OP_COPY) state_d = XWAIT;
`endif
      end
      RWAIT:   state_d = RDAT;
      RDAT:    state_d = DONE;
      WDAT:    state_d = DONE;
`ifdef RAM_SEQ_COPY_EN
      SETT:    state_d = SETA;
      XWAIT:   state_d = XFER;
      XFER:    state_d = (cnt_q == LEN_W'(1)) ? DONE : XWAIT;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode purely from state so an async reset silences them at once.
  always_comb begin
    set_address       = 1'b0;
    set_transfer_addr = 1'b0;
    read              = 1'b0;
    write             = 1'b0;
    data_transfer     = 1'b0;
    half_mode         = 1'b1;
    data_bus          = '0;
    case (state_q)
      SETA: begin
        set_address = 1'b1;
        half_mode   = ~word_q;
        data_bus    = {1'b0, addr_q};
      end
      RWAIT: half_mode = ~word_q;
      RDAT: begin
        read      = 1'b1;
        half_mode = ~word_q;
      end
      WDAT: begin
        write     = 1'b1;
        half_mode = ~word_q;
        data_bus  = word_q ? wdata_q : {8'h00, wdata_q[7:0]};
      end
`ifdef RAM_SEQ_COPY_EN
      SETT: begin
        set_transfer_addr = 1'b1;
        data_bus          = {1'b0, dst_q};
      end
      XFER: begin
        data_transfer = 1'b1;
        data_bus      = {ram_db_out[7:0], 8'h00};
      end
`endif
      default: ;
    endcase
  end

  // Copies force word_q low so the shared SETA state drives half_mode=1 for them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      word_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= req_op;
        word_q  <= req_word & (req_op != OP_COPY);
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= acceptErr;
      end
      if (state_q == RDAT) begin
        rdata_q <= word_q ? ram_db_out : {8'h00, ram_db_out[7:0]};
      end
    end
  end

`ifdef RAM_SEQ_COPY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dst_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      dst_q <= req_dst;
      cnt_q <= req_len;
    end else if (state_q == XFER) begin
      cnt_q <= cnt_q - LEN_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Testbench for ram_access_sequencer: table of directed transactions against a small RAM model,
// plus a hand-written mid-operation reset sequence. Expectations follow RAM_SEQ_COPY_EN.
module tb_ram_access_sequencer;

`ifdef RAM_SEQ_COPY_EN
  localparam bit COPY_EN = 1'b1;
`else
  localparam bit COPY_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic        req_word;
  logic [14:0] req_addr;
  logic [14:0] req_dst;
  logic [8:0]  req_len;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] ram_db_out;
  logic [15:0] data_bus;
  logic        set_address;
  logic        set_transfer_addr;
  logic        read;
  logic        write;
  logic        data_transfer;
  logic        half_mode;

  int compared;
  int mismatched;

  ram_access_sequencer #(.MAX_LEN(256)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_word         (req_word),
    .req_addr         (req_addr),
    .req_dst          (req_dst),
    .req_len          (req_len),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .ram_db_out       (ram_db_out),
    .data_bus         (data_bus),
    .set_address      (set_address),
    .set_transfer_addr(set_transfer_addr),
    .read             (read),
    .write            (write),
    .data_transfer    (data_transfer),
    .half_mode        (half_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: address latches, registered read, byte/word writes, transfer writes.
  logic [7:0]  mem [0:32767];
  logic [14:0] ramAddr;
  logic [14:0] xferAddr;
  logic [15:0] doutReg;
  assign ram_db_out = doutReg;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ramAddr  <= '0;
      xferAddr <= '0;
      doutReg  <= '0;
    end else begin
      doutReg <= {mem[ramAddr + 15'd1], mem[ramAddr]};
      if (set_address)       ramAddr  <= data_bus[14:0];
      if (set_transfer_addr) xferAddr <= data_bus[14:0];
      if (write) begin
        mem[ramAddr] <= data_bus[7:0];
        if (!half_mode) mem[ramAddr + 15'd1] <= data_bus[15:8];
      end
      if (data_transfer) begin
        mem[xferAddr] <= data_bus[15:8];
        xferAddr      <= xferAddr + 15'd1;
        ramAddr       <= ramAddr + 15'd1;
      end
    end
  end

  // Per-transaction bus observations, sampled on the falling edge.
  int  strobeCnt;
  int  xferCnt;
  int  halfZeroCnt;
  int  exclViol;
  int  busViol;
  int  adjXfer;
  logic prevXfer;

  always @(negedge clk) begin
    if (reset_n) begin
      logic [4:0] strobes;
      strobes = {set_address, set_transfer_addr, read, write, data_transfer};
      strobeCnt += $countones(strobes);
      if ($countones(strobes) > 1) exclViol++;
      if (strobes == 5'd0 && data_bus != 16'h0000) busViol++;
      if (!half_mode) halfZeroCnt++;
      if (data_transfer) begin
        xferCnt++;
        if (prevXfer) adjXfer++;
      end
      prevXfer = data_transfer;
    end else begin
      prevXfer = 1'b0;
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic        word;
    logic [14:0] addr;
    logic [14:0] dst;
    logic [8:0]  len;
    logic [15:0] wdata;
    int          lat;
    logic        err;
    logic        chkData;
    logic [15:0] rdata;
    int          strobes;
    int          xfers;
    int          halfZero;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic [1:0] op, input logic word, input logic [14:0] addr,
                        input logic [14:0] dst, input logic [8:0] len, input logic [15:0] wdata,
                        input int lat, input logic err, input logic chkData, input logic [15:0] rdata,
                        input int strobes, input int xfers, input int halfZero);
    vec_t v;
    v.op = op; v.word = word; v.addr = addr; v.dst = dst; v.len = len; v.wdata = wdata;
    v.lat = lat; v.err = err; v.chkData = chkData; v.rdata = rdata;
    v.strobes = strobes; v.xfers = xfers; v.halfZero = halfZero;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request, measures acceptance-to-rsp_valid latency and checks the response.
  task automatic applyStimulus(input int idx, input vec_t v);
    int cyc;
    @(negedge clk);
    req_op = v.op; req_word = v.word; req_addr = v.addr; req_dst = v.dst;
    req_len = v.len; req_wdata = v.wdata; req_valid = 1'b1;
    checkOutput($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
    @(posedge clk);
    strobeCnt = 0; xferCnt = 0; halfZeroCnt = 0; exclViol = 0; busViol = 0; adjXfer = 0;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 600) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL v%0d timeout: got no rsp_valid, expected within %0d cycles", idx, v.lat);
    end else begin
      checkOutput($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.lat));
      checkOutput($sformatf("v%0d rsp_err", idx), 32'(rsp_err), 32'(v.err));
      if (v.chkData) checkOutput($sformatf("v%0d rsp_rdata", idx), 32'(rsp_rdata), 32'(v.rdata));
    end
    @(negedge clk);
    checkOutput($sformatf("v%0d pulse/ready", idx), 32'({rsp_valid, req_ready}), 32'b01);
    checkOutput($sformatf("v%0d strobes", idx), 32'(strobeCnt), 32'(v.strobes));
    checkOutput($sformatf("v%0d xfers", idx), 32'(xferCnt), 32'(v.xfers));
    checkOutput($sformatf("v%0d half0", idx), 32'(halfZeroCnt), 32'(v.halfZero));
    checkOutput($sformatf("v%0d exclusive", idx), 32'(exclViol), 32'd0);
    checkOutput($sformatf("v%0d idle bus", idx), 32'(busViol), 32'd0);
    checkOutput($sformatf("v%0d adjacent xfer", idx), 32'(adjXfer), 32'd0);
  endtask

  initial begin
    compared = 0; mismatched = 0;
    strobeCnt = 0; xferCnt = 0; halfZeroCnt = 0; exclViol = 0; busViol = 0; adjXfer = 0;
    prevXfer = 1'b0;
    reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_word = 1'b0;
    req_addr = '0; req_dst = '0; req_len = '0; req_wdata = '0;

    //     op    w     addr      dst       len  wdata    lat  err  chk rdata  strb xf h0
    addVec(2'd1, 1'b0, 15'h0100, 15'h0000, 9'd0, 16'h0012, 3, 1'b0, 1'b1, 16'h0000, 2, 0, 0);
    addVec(2'd0, 1'b0, 15'h0100, 15'h0000, 9'd0, 16'h0000, 4, 1'b0, 1'b1, 16'h0012, 2, 0, 0);
    addVec(2'd1, 1'b1, 15'h0200, 15'h0000, 9'd0, 16'hBEEF, 3, 1'b0, 1'b1, 16'h0012, 2, 0, 2);
    addVec(2'd0, 1'b1, 15'h0200, 15'h0000, 9'd0, 16'h0000, 4, 1'b0, 1'b1, 16'hBEEF, 2, 0, 3);
    addVec(2'd0, 1'b0, 15'h0201, 15'h0000, 9'd0, 16'h0000, 4, 1'b0, 1'b1, 16'h00BE, 2, 0, 0);
    addVec(2'd1, 1'b0, 15'h0000, 15'h0000, 9'd0, 16'h0055, 3, 1'b0, 1'b0, 16'h0000, 2, 0, 0);
    addVec(2'd1, 1'b0, 15'h7FFF, 15'h0000, 9'd0, 16'h0007, 3, 1'b0, 1'b0, 16'h0000, 2, 0, 0);
    addVec(2'd0, 1'b1, 15'h7FFF, 15'h0000, 9'd0, 16'h0000, 4, 1'b0, 1'b1, 16'h5507, 2, 0, 3);
    addVec(2'd1, 1'b1, 15'h0010, 15'h0000, 9'd0, 16'h2211, 3, 1'b0, 1'b0, 16'h0000, 2, 0, 2);
    addVec(2'd1, 1'b1, 15'h0012, 15'h0000, 9'd0, 16'h4433, 3, 1'b0, 1'b0, 16'h0000, 2, 0, 2);
    addVec(2'd1, 1'b1, 15'h0400, 15'h0000, 9'd0, 16'h0000, 3, 1'b0, 1'b0, 16'h0000, 2, 0, 2);
    addVec(2'd1, 1'b1, 15'h0402, 15'h0000, 9'd0, 16'h0000, 3, 1'b0, 1'b0, 16'h0000, 2, 0, 2);
    addVec(2'd2, 1'b0, 15'h0010, 15'h0400, 9'd4, 16'h0000, COPY_EN ? 11 : 1, !COPY_EN, 1'b1, 16'h5507,
           COPY_EN ? 6 : 0, COPY_EN ? 4 : 0, 0);
    addVec(2'd0, 1'b0, 15'h0400, 15'h0000, 9'd0, 16'h0000, 4, 1'b0, 1'b1, COPY_EN ? 16'h0011 : 16'h0000, 2, 0, 0);
    addVec(2'd0, 1'b0, 15'h0401, 15'h0000, 9'd0, 16'h0000, 4, 1'b0, 1'b1, COPY_EN ? 16'h0022 : 16'h0000, 2, 0, 0);
    addVec(2'd0, 1'b0, 15'h0402, 15'h0000, 9'd0, 16'h0000, 4, 1'b0, 1'b1, COPY_EN ? 16'h0033 : 16'h0000, 2, 0, 0);
    addVec(2'd0, 1'b0, 15'h0403, 15'h0000, 9'd0, 16'h0000, 4, 1'b0, 1'b1, COPY_EN ? 16'h0044 : 16'h0000, 2, 0, 0);
    addVec(2'd3, 1'b0, 15'h0100, 15'h0000, 9'd0, 16'h0000, 1, 1'b1, 1'b1, COPY_EN ? 16'h0044 : 16'h0000, 0, 0, 0);
    addVec(2'd2, 1'b0, 15'h0010, 15'h0600, 9'd0, 16'h0000, 1, !COPY_EN, 1'b0, 16'h0000, 0, 0, 0);
    addVec(2'd2, 1'b0, 15'h7EFE, 15'h0500, 9'd4, 16'h0000, 1, 1'b1, 1'b0, 16'h0000, 0, 0, 0);
    addVec(2'd2, 1'b0, 15'h0010, 15'h7EFF, 9'd2, 16'h0000, 1, 1'b1, 1'b0, 16'h0000, 0, 0, 0);
    addVec(2'd1, 1'b0, 15'h7F00, 15'h0000, 9'd0, 16'h00A5, 3, 1'b0, 1'b0, 16'h0000, 2, 0, 0);
    addVec(2'd0, 1'b0, 15'h7F00, 15'h0000, 9'd0, 16'h0000, 4, 1'b0, 1'b1, 16'h00A5, 2, 0, 0);

    #12;
    checkOutput("reset strobes", 32'({set_address, set_transfer_addr, read, write, data_transfer}), 32'd0);
    checkOutput("reset req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset rsp_valid/err", 32'({rsp_valid, rsp_err}), 32'd0);
    checkOutput("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
    checkOutput("reset half_mode", 32'(half_mode), 32'd1);
    checkOutput("reset data_bus", 32'(data_bus), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Reset while the read sits in RWAIT: outputs must fall back to idle immediately.
    @(negedge clk);
    req_op = 2'd0; req_word = 1'b0; req_addr = 15'h0100; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("midReset SETA strobe", 32'(set_address), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("midReset strobes", 32'({set_address, set_transfer_addr, read, write, data_transfer}), 32'd0);
    checkOutput("midReset req_ready", 32'(req_ready), 32'd1);
    checkOutput("midReset data_bus", 32'(data_bus), 32'd0);
    checkOutput("midReset half_mode", 32'(half_mode), 32'd1);
    checkOutput("midReset rsp_rdata", 32'(rsp_rdata), 32'd0);
    @(negedge clk);
    checkOutput("midReset held strobes", 32'({set_address, read, rsp_valid}), 32'd0);
    reset_n = 1'b1;
    applyStimulus(100, vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram_access_sequencer.md
# ram_access_sequencer

Bus initiator that drives the CPU-side RAM port (address latch, read/write strobes, half/word mode, byte block-transfer) on behalf of a simple request/response client such as a boot loader, debug bridge or future DMA engine. It converts one-cycle-accepted requests into the exact strobe sequences the RAM block expects. It also captures read data from the RAM's OR-combined output bus. It sits beside the CPU control unit, and the two are muxed onto the same RAM control pins at the top level.

## Interface
Parameters:
- MAX_LEN, 256: largest block-copy length in bytes; `len` width is $clog2(MAX_LEN+1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer idle and accepting.
- req_op  in  2  0=read, 1=write, 2=copy, 3=reserved (accepted, completes immediately with rsp_err=1).
- req_word  in  1  1=16-bit access (addr, addr+1), 0=byte.
- req_addr  in  15  RAM byte address (copy: source).
- req_dst  in  15  copy destination.
- req_len  in  $clog2(MAX_LEN+1)  copy length; 0 is legal.
- req_wdata  in  16  write data; byte mode uses [7:0].
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  16  read data; byte reads zero-extend.
- rsp_err  out  1  valid with rsp_valid.
- ram_db_out  in  16  RAM output bus.
- data_bus  out  16  value driven toward RAM data_bus.
- set_address, set_transfer_addr, read, write, data_transfer, half_mode  out  1  RAM control strobes.

## Operation
- States: IDLE, SETA, RWAIT, RDAT, WDAT, SETT, XWAIT, XFER, DONE.
- IDLE: req_ready=1. A request is accepted on req_valid&req_ready. Request fields are registered at acceptance.
- Read: SETA drives set_address=1 with data_bus={0,addr}. RWAIT has all strobes 0 and covers the RAM's registered-read latency. RDAT drives read=1 and captures ram_db_out into rsp_rdata. Byte mode keeps [7:0] and zeroes [15:8]. Then DONE.
- Write: SETA, then WDAT drives write=1 with data_bus=wdata (byte: {8'h00,wdata[7:0]}). Then DONE.
- half_mode = ~req_word during SETA, RWAIT, RDAT and WDAT; otherwise 1.
- Copy: if len=0, go straight to DONE. Otherwise:
  - SETT drives set_transfer_addr=1 with data_bus=dst.
  - SETA drives set_address=1 with data_bus=src and half_mode=1.
  - Then alternate XWAIT (strobes 0) and XFER. XFER drives data_transfer=1 with data_bus[15:8]=ram_db_out[7:0] and data_bus[7:0]=0.
  - The remaining-count register decrements on each XFER. Leave XFER to DONE when the count reaches 0. Cost is 2 cycles per byte.
- DONE: rsp_valid=1 for one cycle, then IDLE.
- Addresses wrap modulo 2^15. Word access at 0x7FFF pairs with 0x0000; the RAM increments its address the same way.
- Error: rsp_err=1 for req_op=3. rsp_err=1 also for a copy whose source or destination range crosses 0x7F00 (memory-mapped region). An erroring copy issues no strobes. Reads and writes into 0x7F00–0x7FFF are legal.
- Strobes are mutually exclusive in every cycle. data_bus=0 in every state that asserts no strobe.

## Timing
- Reset (async assert, sync-released): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, all strobes 0, half_mode=1, data_bus=0.
- Latency from the acceptance edge to rsp_valid:
  - read: 4 cycles (SETA, RWAIT, RDAT, DONE).
  - write: 3 cycles.
  - copy of N≥1 bytes: 3+2N cycles.
  - len=0, error, or op 3: 1 cycle.
- rsp_rdata holds until the next read completes.
- req_ready=0 from the acceptance edge until the cycle after DONE, so back-to-back requests see one idle cycle.
- reset_n asserted mid-operation returns to IDLE immediately with no further strobes. The RAM is reset by the same reset, so no recovery handshake is needed.

## Configuration
- RAM_SEQ_COPY_EN defined: copy op, SETT/XWAIT/XFER states, req_dst/req_len, and data_transfer/set_transfer_addr driving are compiled in.
- Undefined: req_op=2 behaves as reserved (1-cycle rsp_err=1). data_transfer and set_transfer_addr are tied 0, and the count logic is removed.

## Test plan
- Byte write 0x12 to 0x0100, then byte read 0x0100 -> rsp_rdata=0x0012. Write latency 3, read latency 4, half_mode=1 throughout.
- Word write 0xBEEF to 0x0200, then word read -> rsp_rdata=0xBEEF. Byte read of 0x0201 -> 0x00BE.
- Word read of 0x7FFF (clock prescaler, reset 7) paired with 0x0000 preloaded with 0x55 -> rsp_rdata=0x5507.
- Copy len=4 from 0x0010 (11,22,33,44) to 0x0400 -> rsp_valid at cycle 11. Reads of 0x0400..0x0403 return 11,22,33,44. Exactly 4 data_transfer pulses, never adjacent.
- Copy len=0 -> rsp_valid next cycle, no strobes. Copy with src=0x7EFE, len=4 -> rsp_err=1, no strobes. Without RAM_SEQ_COPY_EN, any copy -> rsp_err=1.
- Deassert reset_n during RWAIT -> strobes 0 and req_ready=1 immediately. After release, a new read completes normally.
